// File: rtl/qreg_uart_tx_pkg.sv
// Shared types and line-level constants for the queued UART transmitter.
// QREG_UART_TX_PARITY_EN adds the even-parity bit state to the frame.
package qreg_uart_tx_pkg;

`ifdef QREG_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;
`endif

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic evenParity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/qreg_uart_tx_fifo.sv
// Byte queue feeding the transmitter; a push into a full queue is accepted
// only when a pop happens on the same edge.
module qreg_uart_tx_fifo #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       wrData,
    output logic [7:0]       rdData,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            unique case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; contents are only
    // ever read behind a valid count, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/qreg_uart_tx.sv
// Queued UART transmitter: CPU writes land in a small FIFO, the FSM serialises
// them as 8N1 frames (8E1 when QREG_UART_TX_PARITY_EN is defined).
module qreg_uart_tx
    import qreg_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       triggerQ,
    input  logic [7:0] dbus,
    output logic       txd,
    output logic       full,
    output logic       busy,
    output logic       overflow
);

    localparam int         CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    txState_t         state;
    txState_t         nextState;
    logic [7:0]       baudCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             bitEnd;
    logic             pop;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [7:0]       fifoData;
    logic [CNT_W-1:0] fifoCount;
`ifdef QREG_UART_TX_PARITY_EN
    logic             parityBit;
`endif

    qreg_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (triggerQ),
        .pop    (pop),
        .wrData (dbus),
        .rdData (fifoData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    assign bitEnd = (baudCnt == BAUD_LAST);
    assign pop    = (state == IDLE) && !fifoEmpty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (!fifoEmpty) nextState = START;
            START: if (bitEnd) nextState = DATA;
`ifdef QREG_UART_TX_PARITY_EN
            DATA:   if (bitEnd && bitIdx == 3'd7) nextState = PARITY;
            PARITY: if (bitEnd) nextState = STOP;
`else
            DATA:   if (bitEnd && bitIdx == 3'd7) nextState = STOP;
`endif
            STOP:  if (bitEnd) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        txd = IDLE_LEVEL;
        unique case (state)
            IDLE:   txd = IDLE_LEVEL;
            START:  txd = START_BIT;
            DATA:   txd = shiftReg[0];
`ifdef QREG_UART_TX_PARITY_EN
            PARITY: txd = parityBit;
`endif
            STOP:   txd = STOP_BIT;
            default: txd = IDLE_LEVEL;
        endcase
    end

    assign full = fifoFull;
    assign busy = (state != IDLE) || (fifoCount != '0);

    // Baud counter idles at zero so the start bit gets a full bit period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            if (state == IDLE || bitEnd) baudCnt <= '0;
            else                         baudCnt <= baudCnt + 8'd1;

            if (pop) begin
                shiftReg <= fifoData;
                bitIdx   <= '0;
            end else if (state == DATA && bitEnd) begin
                shiftReg <= {1'b0, shiftReg[7:1]};
                bitIdx   <= bitIdx + 3'd1;
            end
        end
    end

`ifdef QREG_UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    parityBit <= 1'b0;
        else if (pop) parityBit <= evenParity(fifoData);
    end
`endif

    // A write into a full queue survives only if the IDLE pop frees a slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            overflow <= 1'b0;
        else if (triggerQ && fifoFull && !pop) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_qreg_uart_tx.sv
// Scoreboard bench for qreg_uart_tx: a frame-level reference model predicts
// queue occupancy and frame contents; a line monitor captures and compares frames.
module tb_qreg_uart_tx;

    localparam int CLKS  = 4;
    localparam int DEPTH = 4;
`ifdef QREG_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CLKS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       triggerQ = 1'b0;
    logic [7:0] dbus = 8'h00;
    logic       txd;
    logic       full;
    logic       busy;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] modelQ[$];
    logic [7:0] expFrames[$];
    int         edgeNum = 0;
    int         lastPop = -100000;
    int         nextPop = 0;
    logic       mOverflow = 1'b0;
    logic       sawFull = 1'b0;

    logic [63:0] rxVec;
    logic        rxAbort;

    qreg_uart_tx #(
        .CLKS_PER_BIT (CLKS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .triggerQ (triggerQ),
        .dbus     (dbus),
        .txd      (txd),
        .full     (full),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected line samples for one frame, one sample per clock, followed by one idle-high sample.
    function automatic logic [63:0] frameVec(input logic [7:0] b);
        logic [63:0] v;
        int          bitNo;
        v = '0;
        for (int i = 0; i < FRAME; i++) begin
            bitNo = i / CLKS;
            if (bitNo == 0)                   v[i] = 1'b0;
            else if (bitNo <= 8)              v[i] = b[bitNo-1];
            else if (FRAME_BITS == 11 && bitNo == 9) v[i] = ^b;
            else                              v[i] = 1'b1;
        end
        v[FRAME] = 1'b1;
        return v;
    endfunction

    function automatic logic modelBusy();
        return (modelQ.size() > 0) || (edgeNum - lastPop < FRAME);
    endfunction

    function automatic void modelClear();
        modelQ.delete();
        expFrames.delete();
        lastPop   = -100000;
        nextPop   = 0;
        mOverflow = 1'b0;
    endfunction

    // One rising edge of the reference: the transmitter takes the head byte
    // whenever it has finished the previous frame plus one idle clock.
    function automatic void modelEdge(input logic t, input logic [7:0] d);
        logic doPop;
        edgeNum++;
        if (reset) begin
            modelClear();
            return;
        end
        doPop = (modelQ.size() > 0) && (edgeNum >= nextPop);
        if (doPop) begin
            expFrames.push_back(modelQ.pop_front());
            lastPop = edgeNum;
            nextPop = edgeNum + FRAME + 1;
        end
        if (t) begin
            if (modelQ.size() < DEPTH) modelQ.push_back(d);
            else                       mOverflow = 1'b1;
        end
    endfunction

    task automatic cycle(input logic t, input logic [7:0] d);
        triggerQ = t;
        dbus     = d;
        @(posedge clk);
        modelEdge(t, d);
        #1;
        if (full === 1'b1) sawFull = 1'b1;
        check("flags{full,busy,ovf}", 64'({full, busy, overflow}),
              64'({modelQ.size() == DEPTH, modelBusy(), mOverflow}));
        triggerQ = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((modelBusy() || expFrames.size() > 0) && n < 20 * FRAME * DEPTH) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        repeat (3) cycle(1'b0, 8'h00);
        check("frames_outstanding", 64'(expFrames.size()), 64'd0);
    endtask

    task automatic assertReset();
        #2 reset = 1'b1;
        modelClear();
        #1 check("reset_async{txd,busy,full,ovf}", 64'({txd, busy, full, overflow}), 64'b1000);
        repeat (3) cycle(1'b1, 8'($urandom));
        reset = 1'b0;
    endtask

    // Line monitor: a low sample while idle starts a frame capture.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && txd === 1'b0) begin
                rxVec    = '0;
                rxAbort  = 1'b0;
                rxVec[0] = txd;
                for (int i = 1; i <= FRAME; i++) begin
                    @(negedge clk);
                    if (reset) rxAbort = 1'b1;
                    rxVec[i] = txd;
                end
                if (!rxAbort) begin
                    if (expFrames.size() == 0)
                        check("unexpected_frame", rxVec, (64'd1 << (FRAME + 1)) - 64'd1);
                    else
                        check("frame", rxVec, frameVec(expFrames.pop_front()));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        #1 reset = 1'b1;
        #1 check("reset_state{txd,busy,full,ovf}", 64'({txd, busy, full, overflow}), 64'b1000);
        repeat (3) cycle(1'b0, 8'h00);
        reset = 1'b0;
        repeat (2) cycle(1'b0, 8'h00);

        // Single byte while idle: start bit appears on the second edge.
        cycle(1'b1, 8'hA5);
        check("txd_after_1st_edge", 64'(txd), 64'd1);
        cycle(1'b0, 8'h00);
        check("txd_after_2nd_edge", 64'(txd), 64'd0);
        drain();

        // Five consecutive writes fit because the first byte is popped early.
        sawFull = 1'b0;
        for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i));
        drain();
        check("full_seen", 64'(sawFull), 64'd1);
        check("overflow_after_5", 64'(overflow), 64'd0);

        // Write into a full queue on the exact edge of the IDLE pop.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(8'h10 + i));
        n = 0;
        while (edgeNum + 1 != nextPop && n < 4 * FRAME) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check("full_before_pop_write", 64'(full), 64'd1);
        cycle(1'b1, 8'h66);
        check("overflow_pop_write", 64'(overflow), 64'd0);
        drain();

        // Six consecutive writes drop the sixth; overflow stays set.
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(8'h20 + i));
        drain();
        check("overflow_sticky", 64'(overflow), 64'd1);

        // Three drained bursts of four exercise pointer wrap-around.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom));
            drain();
        end

        // Random bursts and gaps.
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) cycle(1'($urandom_range(0, 4) != 0), 8'($urandom));
            n = $urandom_range(0, 50);
            for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
        end
        drain();

        // Reset during DATA bit 3 with a second byte queued: both are discarded.
        cycle(1'b1, 8'h3C);
        cycle(1'b1, 8'h5A);
        n = 0;
        while (edgeNum - lastPop != CLKS + 3 * CLKS + 2 && n < 2 * FRAME) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check("mid_frame_busy", 64'(busy), 64'd1);
        assertReset();
        for (int i = 0; i < 3 * FRAME; i++) cycle(1'b0, 8'h00);
        check("post_reset_overflow", 64'(overflow), 64'd0);

        // Transmitter still works after the abort.
        cycle(1'b1, 8'hC3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
